vx_commit_unit: RTL and testbench
=================================

# VX_commit_unit

Parametrised commit stage for one issue slot. Arbitrates up to NUM_INPUTS execution-unit result streams round-robin into a registered output slot, forwards register-writing results to a writeback port that can apply backpressure, and retires non-writing results without waiting on it. It also keeps aggregate and per-warp retirement counters and emits a registered committed-instruction pulse to the scheduler. One instance sits per issue slot between the execute units and the operand/scoreboard writeback path.

## Interface
Parameters:
- NUM_INPUTS, 4, number of execution-unit streams (≥1)
- NUM_THREADS, 4, lanes per warp
- NUM_WARPS, 4, warps per core (≥2); NW_BITS = clog2(NUM_WARPS)
- PAYLOADW, 64, opaque payload bits (uuid, PC, rd, data)
- PERF_CTR_BITS, 44, counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_INPUTS  per-stream result valid
- in_ready  out  NUM_INPUTS  per-stream accept
- in_wid  in  NUM_INPUTS*NW_BITS  warp id
- in_tmask  in  NUM_INPUTS*NUM_THREADS  active lanes
- in_wb  in  NUM_INPUTS  result writes a register
- in_sop, in_eop  in  NUM_INPUTS each  start/end of packet
- in_payload  in  NUM_INPUTS*PAYLOADW  opaque data
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback accept
- wb_wid, wb_tmask, wb_sop, wb_eop, wb_payload  out  matching widths  writeback fields
- committed  out  1  one-cycle pulse: instruction fully retired
- committed_wid  out  NW_BITS  warp of committed
- instret  out  PERF_CTR_BITS  total retired thread-instructions
- warp_instret  out  NUM_WARPS*PERF_CTR_BITS  retired instructions per warp

## Operation
- Output slot: one register (slot_valid + fields). Slot fires when slot_valid && (!slot_wb || wb_ready). wb_valid = slot_valid && slot_wb; wb_* fields mirror the slot.
- Slot loads when (!slot_valid || fire); otherwise holds with all fields stable.
- Arbiter: round-robin over in_valid. The search starts at index ptr+1 mod NUM_INPUTS, and the first valid input wins. With NUM_INPUTS=1 the arbiter is a pass-through.
- ptr updates to the granted index only on an accepted transfer.
- in_ready[i] = grant[i] && (!slot_valid || fire). Grant depends only on in_valid and ptr; there is no combinational path from in_ready back to arbitration.
- On fire:
  - instret += popcount(slot_tmask), zero-extended.
  - If slot_eop, warp_instret[slot_wid] += 1.
  - Both counters wrap modulo 2^PERF_CTR_BITS.
- committed and committed_wid are registered from (fire && slot_eop, slot_wid). committed_wid holds its last value when committed=0.
- A payload with tmask=0 still fires and retires normally; instret adds 0.
- Reset:
  - slot_valid, ptr, committed, committed_wid, instret and all warp_instret are cleared to 0.
  - Therefore wb_valid=0 and in_ready=0 until the cycle after reset deasserts.
  - Reset asserted while a slot is pending drops that entry; no counter update and no committed pulse result from it.

## Timing
- Input accept to wb_valid: 1 cycle (registered output).
- Throughput: 1 result per cycle while wb_ready=1 or for wb=0 results.
- With wb_ready=0 and a wb=1 result in the slot, all in_ready=0 and ptr is frozen.
- A wb=0 result in the slot fires in the cycle after its acceptance regardless of wb_ready.
- instret and warp_instret reflect a fire on the clock edge that completes it, so they are visible 1 cycle after fire.
- committed pulses 1 cycle after the fire of an eop result.
- Simultaneous fire and load in the same cycle: the slot is replaced with no bubble; counters update for the outgoing entry only.

## Test plan
- Reset, then single input 0: wid=2, tmask=4'b1011, wb=1, eop=1, wb_ready=1.
  - wb_valid rises 1 cycle later with matching fields.
  - Next cycle: instret=3, warp_instret[2]=1, committed=1 with committed_wid=2.
- Fairness: all 4 in_valid held high with wb_ready=1.
  - Grants are 1,2,3,0,1,… (ptr starts at 0).
  - 8 results in 8 consecutive cycles; instret=8×popcount after the last.
- Backpressure: wb=1 result accepted, wb_ready=0 for 5 cycles.
  - wb_valid and fields stable; in_ready=0 throughout; no counter change.
  - When wb_ready=1 it fires, and the next queued input loads in the same cycle.
- Non-writeback bypass: wb=0 result while wb_ready=0.
  - wb_valid stays 0; the result still retires 1 cycle after accept; committed pulses.
- Multi-packet: sop=1/eop=0 followed by sop=0/eop=1 for wid=1, tmask=4'hF.
  - instret +8.
  - warp_instret[1] +1 only, and a single committed pulse, after the second packet.
- Reset mid-operation: reset with a pending wb=1 entry and wb_ready=0.
  - Next cycle wb_valid=0 and all counters 0.
  - No committed pulse; the arbiter restarts its search at input 1.

Source files
------------

// File: rtl/vx_commit_unit_if.sv
// Commit-stage bus bundle: the execute-unit result streams feeding the
// commit unit and the register writeback port leaving it.
//   in_*   : NUM_INPUTS result streams (valid/ready handshake per stream)
//   wb_*   : single writeback stream (valid/ready, backpressure via wb_ready)
// Modports:
//   slave  : commit unit's view (consumes in_*, produces wb_*)
//   master : environment's view (execute units + writeback consumer)
interface vx_commit_unit_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int PAYLOADW    = 64
);
  localparam int NW_BITS = $clog2(NUM_WARPS);

  logic [NUM_INPUTS-1:0]                  in_valid;
  logic [NUM_INPUTS-1:0]                  in_ready;
  logic [NUM_INPUTS-1:0][NW_BITS-1:0]     in_wid;
  logic [NUM_INPUTS-1:0][NUM_THREADS-1:0] in_tmask;
  logic [NUM_INPUTS-1:0]                  in_wb;
  logic [NUM_INPUTS-1:0]                  in_sop;
  logic [NUM_INPUTS-1:0]                  in_eop;
  logic [NUM_INPUTS-1:0][PAYLOADW-1:0]    in_payload;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [NW_BITS-1:0]     wb_wid;
  logic [NUM_THREADS-1:0] wb_tmask;
  logic                   wb_sop;
  logic                   wb_eop;
  logic [PAYLOADW-1:0]    wb_payload;

  modport slave (
    input  in_valid, in_wid, in_tmask, in_wb, in_sop, in_eop, in_payload,
    output in_ready,
    output wb_valid, wb_wid, wb_tmask, wb_sop, wb_eop, wb_payload,
    input  wb_ready
  );

  modport master (
    output in_valid, in_wid, in_tmask, in_wb, in_sop, in_eop, in_payload,
    input  in_ready,
    input  wb_valid, wb_wid, wb_tmask, wb_sop, wb_eop, wb_payload,
    output wb_ready
  );
endinterface

// File: rtl/vx_commit_unit.sv
// Commit stage for one issue slot.
// Round-robin arbitration of NUM_INPUTS result streams into a single
// registered output slot. Register-writing results leave through the
// writeback port (may stall on wb_ready); non-writing results retire the
// cycle after acceptance without waiting. Keeps aggregate thread-instruction
// and per-warp instruction counters and a registered committed pulse.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus            : result streams in, writeback out (vx_commit_unit_if.slave)
//   committed      : 1-cycle pulse, an eop result retired
//   committed_wid  : warp of the last committed pulse (holds otherwise)
//   instret        : total retired thread-instructions (wraps)
//   warp_instret   : retired instructions per warp (wraps)

// Per-warp retirement counter.
module vx_commit_warp_ctr #(
  parameter int W = 44
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset)    count <= '0;
    else if (inc) count <= count + W'(1);
  end
endmodule

module vx_commit_unit #(
  parameter int NUM_INPUTS    = 4,
  parameter int NUM_THREADS   = 4,
  parameter int NUM_WARPS     = 4,
  parameter int PAYLOADW      = 64,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                                    clk,
  input  logic                                    reset,
  vx_commit_unit_if.slave                         bus,
  output logic                                    committed,
  output logic [$clog2(NUM_WARPS)-1:0]            committed_wid,
  output logic [PERF_CTR_BITS-1:0]                instret,
  output logic [NUM_WARPS-1:0][PERF_CTR_BITS-1:0] warp_instret
);
  localparam int NW_BITS = $clog2(NUM_WARPS);
  localparam int PTR_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // ---------------- output slot ----------------
  logic                   slot_valid;
  logic [NW_BITS-1:0]     slot_wid;
  logic [NUM_THREADS-1:0] slot_tmask;
  logic                   slot_wb;
  logic                   slot_sop;
  logic                   slot_eop;
  logic [PAYLOADW-1:0]    slot_payload;

  logic fire, load_en, accept;

  // Non-writing results never look at wb_ready.
  assign fire    = slot_valid && (!slot_wb || bus.wb_ready);
  // No acceptance while reset is held: anything taken would be dropped.
  assign load_en = (!slot_valid || fire) && !reset;

  // ---------------- round-robin arbiter ----------------
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      gidx;
  logic                  gvalid;
  logic [NUM_INPUTS-1:0] grant;

  generate
    if (NUM_INPUTS == 1) begin : g_pass
      assign gvalid = bus.in_valid[0];
      assign gidx   = '0;
    end else begin : g_rr
      logic [PTR_W-1:0] cand;
      // Walk from lowest priority (ptr itself) up to ptr+1; the last valid
      // hit overwrites earlier ones, so ptr+1 wins when valid.
      always_comb begin
        gvalid = 1'b0;
        gidx   = '0;
        cand   = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
          cand = PTR_W'((int'(ptr) + k) % NUM_INPUTS);
          if (bus.in_valid[cand]) begin
            gvalid = 1'b1;
            gidx   = cand;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      grant[i] = gvalid && (gidx == PTR_W'(i));
  end

  assign bus.in_ready = grant & {NUM_INPUTS{load_en}};
  assign accept       = gvalid && load_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      slot_valid <= 1'b0;
    end else begin
      if (accept) ptr <= gidx;
      // Fire and load in the same cycle replace the entry with no bubble.
      if (load_en) slot_valid <= gvalid;
    end
  end

  // Data fields need no reset; they are only meaningful under slot_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_wid     <= bus.in_wid[gidx];
      slot_tmask   <= bus.in_tmask[gidx];
      slot_wb      <= bus.in_wb[gidx];
      slot_sop     <= bus.in_sop[gidx];
      slot_eop     <= bus.in_eop[gidx];
      slot_payload <= bus.in_payload[gidx];
    end
  end

  // ---------------- writeback port ----------------
  assign bus.wb_valid   = slot_valid && slot_wb;
  assign bus.wb_wid     = slot_wid;
  assign bus.wb_tmask   = slot_tmask;
  assign bus.wb_sop     = slot_sop;
  assign bus.wb_eop     = slot_eop;
  assign bus.wb_payload = slot_payload;

  // ---------------- retirement counters ----------------
  logic [PERF_CTR_BITS-1:0] lane_cnt;

  always_comb begin
    lane_cnt = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      lane_cnt = lane_cnt + PERF_CTR_BITS'(slot_tmask[t]);
  end

  always_ff @(posedge clk) begin
    if (reset)     instret <= '0;
    else if (fire) instret <= instret + lane_cnt;
  end

  genvar w;
  generate
    for (w = 0; w < NUM_WARPS; w++) begin : g_warp
      vx_commit_warp_ctr #(.W(PERF_CTR_BITS)) u_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (fire && slot_eop && (slot_wid == NW_BITS'(w))),
        .count (warp_instret[w])
      );
    end
  endgenerate

  // Only the eop packet of an instruction counts as a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      committed     <= 1'b0;
      committed_wid <= '0;
    end else begin
      committed <= fire && slot_eop;
      if (fire && slot_eop) committed_wid <= slot_wid;
    end
  end
endmodule

// File: tb/tb_vx_commit_unit.sv
module tb_vx_commit_unit;
  localparam int NI = 4, NT = 4, NW = 4, PW = 64, CB = 44;

  logic clk = 1'b0;
  logic reset;
  logic committed;
  logic [1:0] committed_wid;
  logic [CB-1:0] instret;
  logic [NW-1:0][CB-1:0] warp_instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_commit_unit_if #(.NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_WARPS(NW), .PAYLOADW(PW)) bus ();

  vx_commit_unit #(
    .NUM_INPUTS(NI), .NUM_THREADS(NT), .NUM_WARPS(NW), .PAYLOADW(PW), .PERF_CTR_BITS(CB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .committed     (committed),
    .committed_wid (committed_wid),
    .instret       (instret),
    .warp_instret  (warp_instret)
  );

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [1:0]    wid;
    logic [NT-1:0] tmask;
    logic          wb;
    logic          sop;
    logic          eop;
    logic [PW-1:0] payload;
  } ent_t;

  logic          m_valid = 1'b0;
  ent_t          m_ent   = '0;
  int            m_ptr   = 0;
  logic [CB-1:0] m_instret = '0;
  logic [CB-1:0] m_warp [NW] = '{default: '0};
  logic          m_comm = 1'b0;
  logic [1:0]    m_cwid = '0;

  // Round robin: first valid stream searching from last winner + 1.
  function automatic int pick(input logic [NI-1:0] v, input int p);
    for (int k = 1; k <= NI; k++)
      if (v[(p + k) % NI]) return (p + k) % NI;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0; m_ptr = 0; m_instret = '0; m_comm = 1'b0; m_cwid = '0;
      for (int w = 0; w < NW; w++) m_warp[w] = '0;
    end else begin
      automatic logic f  = m_valid && (!m_ent.wb || bus.wb_ready);
      automatic logic sp = !m_valid || f;
      automatic int   g  = pick(bus.in_valid, m_ptr);
      m_comm = f && m_ent.eop;
      if (f) begin
        m_instret = m_instret + CB'($countones(m_ent.tmask));
        if (m_ent.eop) begin
          m_warp[m_ent.wid] = m_warp[m_ent.wid] + 1;
          m_cwid = m_ent.wid;
        end
      end
      if (sp) begin
        if (g >= 0) begin
          m_ent = '{wid: bus.in_wid[g], tmask: bus.in_tmask[g], wb: bus.in_wb[g],
                    sop: bus.in_sop[g], eop: bus.in_eop[g], payload: bus.in_payload[g]};
          m_ptr = g;
          m_valid = 1'b1;
        end else m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic cmp_model();
    automatic logic f  = m_valid && (!m_ent.wb || bus.wb_ready);
    automatic logic sp = (!m_valid || f) && !reset;
    automatic int   g  = pick(bus.in_valid, m_ptr);
    automatic logic [NI-1:0] er = (sp && g >= 0) ? NI'(1 << g) : '0;
    chk("in_ready", 64'(bus.in_ready), 64'(er));
    chk("wb_valid", 64'(bus.wb_valid), 64'(m_valid && m_ent.wb));
    if (m_valid && m_ent.wb) begin
      chk("wb_wid",     64'(bus.wb_wid),   64'(m_ent.wid));
      chk("wb_tmask",   64'(bus.wb_tmask), 64'(m_ent.tmask));
      chk("wb_sop",     64'(bus.wb_sop),   64'(m_ent.sop));
      chk("wb_eop",     64'(bus.wb_eop),   64'(m_ent.eop));
      chk("wb_payload", bus.wb_payload,    m_ent.payload);
    end
    chk("committed",     64'(committed),     64'(m_comm));
    chk("committed_wid", 64'(committed_wid), 64'(m_cwid));
    chk("instret",       64'(instret),       64'(m_instret));
    for (int w = 0; w < NW; w++)
      chk($sformatf("warp_instret%0d", w), 64'(warp_instret[w]), 64'(m_warp[w]));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic at_neg();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.in_valid = '0;
  endtask

  task automatic set_in(input int i, input int wid, input logic [NT-1:0] tm,
                        input logic wb, input logic sop, input logic eop);
    bus.in_valid[i]   = 1'b1;
    bus.in_wid[i]     = 2'(wid);
    bus.in_tmask[i]   = tm;
    bus.in_wb[i]      = wb;
    bus.in_sop[i]     = sop;
    bus.in_eop[i]     = eop;
    bus.in_payload[i] = {$urandom, $urandom};
  endtask

  task automatic step();
    at_neg();
    to_next();
  endtask

  task automatic drain();
    clr();
    bus.wb_ready = 1'b1;
    repeat (3) step();
  endtask

  logic [CB-1:0] base_i, base_w;

  initial begin
    reset = 1'b1;
    bus.in_valid = '0; bus.in_wid = '0; bus.in_tmask = '0; bus.in_wb = '0;
    bus.in_sop = '0; bus.in_eop = '0; bus.in_payload = '0;
    bus.wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    at_neg();
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_committed", 64'(committed), 64'd0);
    to_next();

    // Single result on stream 0.
    set_in(0, 2, 4'b1011, 1'b1, 1'b1, 1'b1);
    at_neg();
    chk("t1_in_ready", 64'(bus.in_ready), 64'h1);
    to_next();
    clr();
    at_neg();
    chk("t1_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_wb_wid", 64'(bus.wb_wid), 64'd2);
    chk("t1_wb_tmask", 64'(bus.wb_tmask), 64'hb);
    to_next();
    at_neg();
    chk("t1_instret", 64'(instret), 64'd3);
    chk("t1_warp2", 64'(warp_instret[2]), 64'd1);
    chk("t1_committed", 64'(committed), 64'd1);
    chk("t1_cwid", 64'(committed_wid), 64'd2);
    to_next();

    // Fairness: all streams valid, grants 1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NI; i++) set_in(i, i, 4'b0111, 1'b1, 1'b1, 1'b1);
      at_neg();
      chk("rr_grant", 64'(bus.in_ready), 64'(1 << ((k + 1) % NI)));
      to_next();
    end
    clr();
    step();
    at_neg();
    chk("rr_instret", 64'(instret), 64'd27);
    to_next();
    drain();

    // Backpressure on a writing result; a non-writing one queued behind it.
    bus.wb_ready = 1'b0;
    set_in(2, 3, 4'b0011, 1'b1, 1'b1, 1'b1);
    at_neg();
    chk("bp_accept", 64'(bus.in_ready), 64'h4);
    to_next();
    clr();
    set_in(3, 0, 4'b0001, 1'b0, 1'b1, 1'b1);
    base_i = m_instret;
    repeat (5) begin
      at_neg();
      chk("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_wb_wid", 64'(bus.wb_wid), 64'd3);
      chk("bp_instret_hold", 64'(instret), 64'(base_i));
      to_next();
    end
    bus.wb_ready = 1'b1;
    at_neg();
    chk("bp_release_load", 64'(bus.in_ready), 64'h8);
    to_next();
    clr();
    bus.wb_ready = 1'b0;
    at_neg();
    chk("bp_nowb_valid", 64'(bus.wb_valid), 64'd0);
    to_next();
    at_neg();
    chk("bp_nowb_commit", 64'(committed), 64'd1);
    chk("bp_nowb_cwid", 64'(committed_wid), 64'd0);
    to_next();
    drain();

    // Non-writeback bypass while wb_ready is low.
    bus.wb_ready = 1'b0;
    set_in(1, 1, 4'b0110, 1'b0, 1'b1, 1'b1);
    at_neg();
    chk("byp_accept", 64'(bus.in_ready), 64'h2);
    to_next();
    clr();
    at_neg();
    chk("byp_wb_valid", 64'(bus.wb_valid), 64'd0);
    to_next();
    at_neg();
    chk("byp_committed", 64'(committed), 64'd1);
    chk("byp_cwid", 64'(committed_wid), 64'd1);
    to_next();
    drain();

    // Two-packet instruction for warp 1.
    set_in(0, 1, 4'hf, 1'b1, 1'b1, 1'b0);
    at_neg();
    base_i = m_instret;
    base_w = m_warp[1];
    to_next();
    set_in(0, 1, 4'hf, 1'b1, 1'b0, 1'b1);
    step();
    clr();
    at_neg();
    chk("mp_no_commit_first", 64'(committed), 64'd0);
    chk("mp_warp1_mid", 64'(warp_instret[1]), 64'(base_w));
    to_next();
    at_neg();
    chk("mp_committed", 64'(committed), 64'd1);
    chk("mp_instret", 64'(instret), 64'(base_i + 8));
    chk("mp_warp1", 64'(warp_instret[1]), 64'(base_w + 1));
    to_next();
    at_neg();
    chk("mp_single_pulse", 64'(committed), 64'd0);
    to_next();

    // Reset while a writing result is stalled.
    bus.wb_ready = 1'b0;
    set_in(2, 2, 4'b1111, 1'b1, 1'b1, 1'b1);
    step();
    for (int i = 0; i < NI; i++) set_in(i, i, 4'b0101, 1'b1, 1'b1, 1'b1);
    at_neg();
    chk("rm_stalled", 64'(bus.in_ready), 64'd0);
    to_next();
    reset = 1'b1;
    at_neg();
    chk("rm_ready_in_reset", 64'(bus.in_ready), 64'd0);
    to_next();
    reset = 1'b0;
    at_neg();
    chk("rm_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rm_instret", 64'(instret), 64'd0);
    chk("rm_warp2", 64'(warp_instret[2]), 64'd0);
    chk("rm_committed", 64'(committed), 64'd0);
    chk("rm_restart", 64'(bus.in_ready), 64'h2);
    to_next();
    clr();
    bus.wb_ready = 1'b1;

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        bus.in_valid[i]   = ($urandom_range(0, 99) < 45);
        bus.in_wid[i]     = 2'($urandom);
        bus.in_tmask[i]   = NT'($urandom);
        bus.in_wb[i]      = $urandom_range(0, 1) == 1;
        bus.in_sop[i]     = $urandom_range(0, 1) == 1;
        bus.in_eop[i]     = $urandom_range(0, 2) != 0;
        bus.in_payload[i] = {$urandom, $urandom};
      end
      bus.wb_ready = ($urandom_range(0, 99) < 65);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
